// File: rtl/step_pulse_pkg.sv
// Shared definitions for the push-button step pulse generator:
// FSM state encoding and a width helper for the cycle counter.
package step_pulse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DB_PRESS   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_DB_RELEASE = 3'd4
  } state_e;

  // Bits needed to count 0..value-1.
  function automatic int clog2_f(input int unsigned value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Metastability filter: s1 may go metastable, s2 is the clean copy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Debounces a raw push-button and emits one-clock step pulses per press,
// with optional auto-repeat while the button is held.
module step_pulse_gen
  import step_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic repeat_en,
  output logic step,
  output logic pressed
);

  localparam int unsigned MAX_A   = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;

  if (CNT_W < clog2_f(MAX_CYC)) begin : g_cnt_w_check
    $error("step_pulse_gen: CNT_W cannot hold the largest cycle count");
  end

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

  logic             btn_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             step_q;
  logic             pressed_q;

  sync_2ff u_btn_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (btn),
    .q_o    (btn_s)
  );

  // Press/hold/release FSM; pressed_q tracks the state being entered so it
  // rises with the accepting step and falls on the edge that returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      step_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pressed_q <= 1'b0;
          cnt_q     <= {CNT_W{1'b0}};
          if (btn_s) begin
            state_q <= ST_DB_PRESS;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DB_PRESS: begin
          pressed_q <= 1'b0;
          if (!btn_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
          end else if (cnt_q == DB_LAST) begin
            state_q   <= ST_HELD;
            cnt_q     <= {CNT_W{1'b0}};
            step_q    <= 1'b1;
            pressed_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HELD: begin
          pressed_q <= 1'b1;
          if (!btn_s) begin
            state_q <= ST_DB_RELEASE;
            cnt_q   <= {CNT_W{1'b0}};
          end else if (!repeat_en) begin
            cnt_q <= {CNT_W{1'b0}};
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= ST_REPEAT;
            cnt_q   <= {CNT_W{1'b0}};
            step_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          // Release outranks the repeat terminal count: no step on that cycle.
          pressed_q <= 1'b1;
          if (!btn_s) begin
            state_q <= ST_DB_RELEASE;
            cnt_q   <= {CNT_W{1'b0}};
          end else if (!repeat_en) begin
            state_q <= ST_HELD;
            cnt_q   <= {CNT_W{1'b0}};
          end else if (cnt_q == REP_LAST) begin
            cnt_q  <= {CNT_W{1'b0}};
            step_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DB_RELEASE: begin
          if (btn_s) begin
            state_q   <= ST_HELD;
            cnt_q     <= {CNT_W{1'b0}};
            pressed_q <= 1'b1;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            pressed_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q + CNT_ONE;
            pressed_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= {CNT_W{1'b0}};
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign step    = step_q;
  assign pressed = pressed_q;

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
Upstream stage for the T-flip-flop mod-N digit counter. It takes a raw, bouncing push-button, then synchronises and debounces it. Each accepted press produces a single-clock `step` pulse that drives the counter's enable input. When `repeat_en` is set and the button is held, it auto-repeats steps at a fixed rate, so a held key advances the displayed digit continuously.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples needed to accept a press or a release (>=1).
- HOLD_CYCLES, 25000000: clocks in HELD before auto-repeat starts (>=2).
- REPEAT_CYCLES, 5000000: clocks between auto-repeat steps (>=2).
- CNT_W, 25: width of the shared cycle counter; must hold max(all three)-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Sets all state to reset values immediately; deassertion is seen synchronously.
- btn  in  1  raw button, asynchronous to clk, active-high, may bounce.
- repeat_en  in  1  allows auto-repeat while held; synchronous level.
- step  out  1  one-clock pulse per accepted press or repeat; registered.
- pressed  out  1  debounced button level; registered.

Behaviour:
- Reset values: `step`=0, `pressed`=0, sync flops=0, state=IDLE, cnt=0.
- Synchroniser: btn -> s1 -> s2 (2 flops). Only s2 (btn_s) feeds the FSM.
- Single counter cnt[CNT_W-1:0] shared by all states. It clears on every state change.
- `step` defaults to 0 each cycle and is set to 1 only on the transitions marked STEP below.
- IDLE: `pressed`=0. btn_s=1 -> DB_PRESS.
- DB_PRESS:
  - btn_s=0 -> IDLE, no step.
  - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, STEP.
  - otherwise cnt++.
- HELD: `pressed`=1.
  - btn_s=0 -> DB_RELEASE.
  - repeat_en=1 and cnt==HOLD_CYCLES-1 -> REPEAT, STEP.
  - repeat_en=0: cnt holds at 0 and no repeat occurs.
- REPEAT: `pressed`=1.
  - btn_s=0 -> DB_RELEASE.
  - repeat_en=0 -> HELD, no step.
  - cnt==REPEAT_CYCLES-1 -> STEP, cnt=0, stay in REPEAT.
- DB_RELEASE: `pressed`=1.
  - btn_s=1 -> HELD, no step, so a release bounce never double-counts.
  - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; `pressed` falls on that edge.
- Latency: btn first sampled high at edge k, held stable. `step` is high for exactly the clock after edge k+DEBOUNCE_CYCLES+2.
- `step` is never high on two consecutive clocks. A press shorter than DEBOUNCE_CYCLES+1 sampled cycles produces no step.
- Priority when several conditions hold in one cycle: btn_s=0 in HELD/REPEAT wins over the repeat terminal count, so no step is issued on the release cycle.
- Reset asserted mid-operation: `step` and `pressed` drop asynchronously. After deassertion the FSM restarts in IDLE even if btn is still high, and the press is re-debounced (one fresh step).
- No wrap of cnt: every state leaves or clears cnt before it reaches 2^CNT_W.

Decomposition:
- Shared package step_pulse_pkg:
  - state encoding constants (IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE; 3 bits);
  - a clog2 helper used for CNT_W checking.
- One sub-module: sync_2ff (1-bit two-flop synchroniser with the same clk/rst). It is reused by any future button inputs.
- Timing FSM and counter stay in step_pulse_gen.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3):
- Clean press: btn 0->1 at edge 0, held 30 clocks, repeat_en=0 -> `step` high only in the clock after edge 6 (one pulse total); `pressed`=1 from edge 6.
- Bounce: btn toggles 1,0,1,0 on alternate clocks, then stays high -> no step during bouncing; exactly one step 6 clocks after the final rising sample.
- Auto-repeat: repeat_en=1, btn held 40 clocks -> first step after edge 6, second 10 clocks later, then one every 3 clocks until release; never two adjacent pulses.
- Release bounce: after a press, btn drops 2 clocks, rises 1, then stays low -> no extra step; `pressed` falls 4 clocks after the final low reaches btn_s.
- Reset mid-hold: rst=0 for 2 clocks while in REPEAT with btn still high -> `step`/`pressed` go 0 asynchronously. After release of reset, one new step appears 6 clocks after the first sampled high.
- Short glitch: btn high for 3 clocks then low -> no step, `pressed` stays 0, FSM back in IDLE.
